// File: rtl/pong_pkg.sv
// pong_pkg: shared types and constants for the VGA Pong game controller.
//   - pong_state_e : controller state, encoded IDLE=0, PLAY=1, MISS=2, OVER=3
//   - screen, ball and paddle geometry defaults
//   - sat_inc8     : saturating 8-bit increment used for the score
package pong_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StPlay = 2'd1,
        StMiss = 2'd2,
        StOver = 2'd3
    } pong_state_e;

    localparam int unsigned SCREEN_W  = 640;
    localparam int unsigned SCREEN_H  = 480;
    localparam int unsigned BALL_SIZE = 16;

    // Serve point is the ball's top-left corner with the ball centred on screen.
    localparam int unsigned DEF_BALL_X0      = SCREEN_W / 2 - BALL_SIZE / 2;   // 312
    localparam int unsigned DEF_BALL_Y0      = SCREEN_H / 2 - BALL_SIZE / 2;   // 232
    // Ball top at this row means its bottom edge has passed the paddle line.
    localparam int unsigned DEF_MISS_Y       = SCREEN_H - BALL_SIZE - 8;       // 456
    localparam int unsigned DEF_PADDLE_STEP  = 4;
    localparam int unsigned DEF_PADDLE_MAX   = 504;
    localparam int unsigned DEF_LIVES        = 3;
    localparam int unsigned DEF_MISS_FRAMES  = 60;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/pong_axis_step.sv
// pong_axis_step: one axis of ball motion.
//   Holds the position register, direction bit (1 = decrement) and the two
//   sticky collision latches for this axis. At each frame_tick the latches are
//   consumed (OR the same-cycle pulses) and cleared; when enabled the axis
//   applies the hold/bounce/move rule.
// Ports:
//   clk, reset          : clock, async active-high reset
//   frame_tick          : once-per-frame update strobe
//   enable              : apply the motion rule on this tick
//   col_lo, col_hi      : low-side (left/top) and high-side (right/bottom) hits
//   force_dir1          : force direction to 1 after this tick's move
//   load, load_pos/dir  : overriding load of position and direction
//   pos                 : current position
//   pos_next            : position the motion rule would produce this tick
module pong_axis_step #(
    parameter int unsigned  W         = 10,
    parameter logic [W-1:0] RESET_POS = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         frame_tick,
    input  logic         enable,
    input  logic         col_lo,
    input  logic         col_hi,
    input  logic         force_dir1,
    input  logic         load,
    input  logic [W-1:0] load_pos,
    input  logic         load_dir,
    output logic [W-1:0] pos,
    output logic [W-1:0] pos_next
);

    localparam logic [W-1:0] One = W'(1);

    logic [W-1:0] pos_q, pos_d;
    logic         dir_q, dir_d;
    logic         lat_lo_q, lat_lo_d;
    logic         lat_hi_q, lat_hi_d;

    logic         hit_lo, hit_hi, hold, dir_step;

    // Motion rule: simultaneous hits on both sides freeze the axis; otherwise
    // the high side wins, and the move uses the updated direction.
    always_comb begin
        hit_lo   = lat_lo_q | col_lo;
        hit_hi   = lat_hi_q | col_hi;
        hold     = hit_lo & hit_hi;
        dir_step = dir_q;
        if (!hold) begin
            if (hit_hi) begin
                dir_step = 1'b1;
            end else if (hit_lo) begin
                dir_step = 1'b0;
            end
        end
        if (hold) begin
            pos_next = pos_q;
        end else if (dir_step) begin
            pos_next = pos_q - One;
        end else begin
            pos_next = pos_q + One;
        end
    end

    always_comb begin
        pos_d = pos_q;
        dir_d = dir_q;
        if (load) begin
            pos_d = load_pos;
            dir_d = load_dir;
        end else if (frame_tick && enable) begin
            pos_d = pos_next;
            dir_d = dir_step | force_dir1;
        end
    end

    // Latches are cleared on every tick whether or not the axis is enabled,
    // so hits from a frozen frame never leak into play.
    always_comb begin
        lat_lo_d = frame_tick ? 1'b0 : (lat_lo_q | col_lo);
        lat_hi_d = frame_tick ? 1'b0 : (lat_hi_q | col_hi);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pos_q    <= RESET_POS;
            dir_q    <= 1'b0;
            lat_lo_q <= 1'b0;
            lat_hi_q <= 1'b0;
        end else begin
            pos_q    <= pos_d;
            dir_q    <= dir_d;
            lat_lo_q <= lat_lo_d;
            lat_hi_q <= lat_hi_d;
        end
    end

    assign pos = pos_q;

endmodule

// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: frame-rate game controller for VGA Pong.
//   Advances ball, paddle, lives and score once per frame_tick from the
//   renderer's collision pulses and the user inputs. All outputs registered.
// Ports:
//   clk, reset                     : pixel clock, async active-high reset
//   frame_tick                     : one-cycle pulse per frame
//   col_x1/x2/y1/y2                : left/right/top/bottom ball-edge hits
//   col_paddle                     : ball bottom hit the paddle
//   btn_serve                      : serve / restart request pulse
//   pad_left, pad_right            : paddle move levels
//   ball_x, ball_y                 : ball top-left corner
//   paddle_pos                     : paddle left offset
//   lives, score, state            : game status (state IDLE=0 PLAY=1 MISS=2 OVER=3)
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int unsigned BALL_X0     = DEF_BALL_X0,
    parameter int unsigned BALL_Y0     = DEF_BALL_Y0,
    parameter int unsigned MISS_Y      = DEF_MISS_Y,
    parameter int unsigned PADDLE_STEP = DEF_PADDLE_STEP,
    parameter int unsigned PADDLE_MAX  = DEF_PADDLE_MAX,
    parameter int unsigned LIVES       = DEF_LIVES,
    parameter int unsigned MISS_FRAMES = DEF_MISS_FRAMES
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       col_x1,
    input  logic       col_x2,
    input  logic       col_y1,
    input  logic       col_y2,
    input  logic       col_paddle,
    input  logic       btn_serve,
    input  logic       pad_left,
    input  logic       pad_right,
    output logic [9:0] ball_x,
    output logic [8:0] ball_y,
    output logic [8:0] paddle_pos,
    output logic [2:0] lives,
    output logic [7:0] score,
    output logic [1:0] state
);

    localparam logic [9:0] BallX0     = 10'(BALL_X0);
    localparam logic [8:0] BallY0     = 9'(BALL_Y0);
    // The serve tick already takes the first step: right and up.
    localparam logic [9:0] ServeX     = 10'(BALL_X0 + 1);
    localparam logic [8:0] ServeY     = 9'(BALL_Y0 - 1);
    localparam logic [8:0] MissY      = 9'(MISS_Y);
    localparam logic [8:0] PadStep    = 9'(PADDLE_STEP);
    localparam logic [8:0] PadMax     = 9'(PADDLE_MAX);
    localparam logic [8:0] PadReset   = 9'(PADDLE_MAX / 2);
    localparam logic [2:0] LivesInit  = 3'(LIVES);
    localparam logic [7:0] FreezeInit = 8'(MISS_FRAMES);

    pong_state_e state_q, state_d;

    logic [2:0] lives_q, lives_d;
    logic [7:0] score_q, score_d;
    logic [8:0] paddle_q, paddle_d;
    logic [7:0] freeze_q, freeze_d;
    logic       serve_pend_q, serve_pend_d;
    logic       col_paddle_q, col_paddle_d;

    logic       play_en, paddle_eff, serve_eff, freeze_done, miss;
    logic       load_ball, load_x_dir, load_y_dir;
    logic [9:0] load_x_pos;
    logic [8:0] load_y_pos;
    logic [8:0] ball_y_next;
    logic [9:0] unused_ball_x_next;
    logic [9:0] pad_sum;
    logic [8:0] pad_move;

    assign play_en     = (state_q == StPlay);
    assign paddle_eff  = col_paddle_q | col_paddle;
    assign serve_eff   = serve_pend_q | btn_serve;
    assign freeze_done = (freeze_q <= 8'd1);
    assign miss        = (ball_y_next >= MissY);

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (frame_tick && serve_eff) state_d = StPlay;
            StPlay: if (frame_tick && miss) state_d = StMiss;
            StMiss: begin
                if (frame_tick && freeze_done) begin
                    state_d = (lives_q == 3'd0) ? StOver : StIdle;
                end
            end
            StOver: if (btn_serve) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        load_ball  = 1'b0;
        load_x_pos = BallX0;
        load_y_pos = BallY0;
        load_x_dir = 1'b0;
        load_y_dir = 1'b0;
        lives_d    = lives_q;
        score_d    = score_q;
        freeze_d   = freeze_q;

        // Paddle step with clamping; widened sum so the upper clamp cannot wrap.
        pad_sum = {1'b0, paddle_q} + {1'b0, PadStep};
        if (pad_right && !pad_left) begin
            pad_move = (pad_sum > {1'b0, PadMax}) ? PadMax : pad_sum[8:0];
        end else if (pad_left && !pad_right) begin
            pad_move = (paddle_q < PadStep) ? 9'd0 : paddle_q - PadStep;
        end else begin
            pad_move = paddle_q;
        end
        paddle_d = (frame_tick && state_q != StOver) ? pad_move : paddle_q;

        col_paddle_d = frame_tick ? 1'b0 : (col_paddle_q | col_paddle);
        // A serve press in OVER is the restart itself, not a pending serve.
        if (frame_tick || state_q == StOver) begin
            serve_pend_d = 1'b0;
        end else begin
            serve_pend_d = serve_pend_q | btn_serve;
        end

        unique case (state_q)
            StIdle: begin
                if (frame_tick && serve_eff) begin
                    load_ball  = 1'b1;
                    load_x_pos = ServeX;
                    load_y_pos = ServeY;
                    load_y_dir = 1'b1;
                end
            end
            StPlay: begin
                if (frame_tick) begin
                    if (paddle_eff) score_d = sat_inc8(score_q);
                    if (miss) begin
                        lives_d  = lives_q - 3'd1;
                        freeze_d = FreezeInit;
                    end
                end
            end
            StMiss: begin
                if (frame_tick) begin
                    freeze_d = freeze_done ? 8'd0 : freeze_q - 8'd1;
                    if (freeze_done && lives_q != 3'd0) load_ball = 1'b1;
                end
            end
            StOver: begin
                if (btn_serve) begin
                    load_ball = 1'b1;
                    lives_d   = LivesInit;
                    score_d   = 8'd0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lives_q      <= LivesInit;
            score_q      <= 8'd0;
            paddle_q     <= PadReset;
            freeze_q     <= 8'd0;
            serve_pend_q <= 1'b0;
            col_paddle_q <= 1'b0;
        end else begin
            lives_q      <= lives_d;
            score_q      <= score_d;
            paddle_q     <= paddle_d;
            freeze_q     <= freeze_d;
            serve_pend_q <= serve_pend_d;
            col_paddle_q <= col_paddle_d;
        end
    end

    // ---------------------------------------------------------- ball axes
    pong_axis_step #(
        .W         (10),
        .RESET_POS (BallX0)
    ) u_axis_x (
        .clk        (clk),
        .reset      (reset),
        .frame_tick (frame_tick),
        .enable     (play_en),
        .col_lo     (col_x1),
        .col_hi     (col_x2),
        .force_dir1 (1'b0),
        .load       (load_ball),
        .load_pos   (load_x_pos),
        .load_dir   (load_x_dir),
        .pos        (ball_x),
        .pos_next   (unused_ball_x_next)
    );

    pong_axis_step #(
        .W         (9),
        .RESET_POS (BallY0)
    ) u_axis_y (
        .clk        (clk),
        .reset      (reset),
        .frame_tick (frame_tick),
        .enable     (play_en),
        .col_lo     (col_y1),
        .col_hi     (col_y2),
        .force_dir1 (paddle_eff),
        .load       (load_ball),
        .load_pos   (load_y_pos),
        .load_dir   (load_y_dir),
        .pos        (ball_y),
        .pos_next   (ball_y_next)
    );

    assign paddle_pos = paddle_q;
    assign lives      = lives_q;
    assign score      = score_q;
    assign state      = state_q;

endmodule
